cv32e40s_rf_wport_arbiter: RTL and testbench

Register file write-port arbiter that shares the single register file write port between the pipeline writeback stage and NUM_AUX auxiliary writers (e.g. a multi-cycle unit's late result, debug-access writes). The writeback stage has absolute priority and is never backpressured. Auxiliary writers are served round-robin over a valid/ready handshake. A starvation counter forces a one-cycle writeback stall when auxiliary writers are locked out too long. It sits between the WB stage / auxiliary sources and the register file write port.

---
 rtl/cv32e40s_pkg.sv | 24 ++
 rtl/cv32e40s_rr_pick.sv | 36 +++
 rtl/cv32e40s_rf_wport_arbiter.sv | 148 ++++++++++++++
 tb/tb_cv32e40s_rf_wport_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the cv32e40s register file write path.
//   rf_addr_t            : register file address (x0..x31)
//   rf_data_t            : register file data word
//   rf_wport_arb_state_e : starvation FSM states of the write-port arbiter
//   RF_WPORT_STARVE_LIMIT: default blocked-cycle budget before a WB stall
package cv32e40s_pkg;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbWait  = 2'd1,
    ArbStall = 2'd2
  } rf_wport_arb_state_e;

  localparam int unsigned RF_WPORT_STARVE_LIMIT = 4;

  // Width of an index over n items; never zero so a single item still has a wire.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40s_rr_pick.sv
// Combinational round-robin one-hot picker.
//   req_i     : request vector, one bit per requester
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : one-hot (or zero) grant to the first request at/after ptr_i
//   gnt_idx_o : binary index of the granted requester (0 when no grant)
module cv32e40s_rr_pick
  import cv32e40s_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] gnt_idx_o
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < int'(N); off++) begin
      idx = PtrW'(unsigned'((int'(ptr_i) + off) % int'(N)));
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40s_rf_wport_arbiter.sv
// Register file write-port arbiter. The WB stage owns the port whenever it writes a
// non-zero register; otherwise auxiliary writers are served round-robin over
// valid/ready. A starvation FSM requests a one-cycle WB stall after STARVE_LIMIT
// consecutive cycles in which auxiliary writers were valid but none was served.
//   clk, rst                 : clock, asynchronous active-high reset
//   wb_we_i/waddr_i/wdata_i  : writeback stage write request (never backpressured)
//   wb_stall_o               : registered request to hold WB for one cycle
//   aux_valid_i/waddr_i/wdata_i, aux_ready_o : auxiliary writer handshakes
//   rf_we_o/waddr_o/wdata_o  : register file write port
module cv32e40s_rf_wport_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int unsigned NUM_AUX      = 2,
  parameter int unsigned STARVE_LIMIT = RF_WPORT_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         wb_we_i,
  input  rf_addr_t                     wb_waddr_i,
  input  rf_data_t                     wb_wdata_i,
  output logic                         wb_stall_o,

  input  logic     [NUM_AUX-1:0]       aux_valid_i,
  input  rf_addr_t [NUM_AUX-1:0]       aux_waddr_i,
  input  rf_data_t [NUM_AUX-1:0]       aux_wdata_i,
  output logic     [NUM_AUX-1:0]       aux_ready_o,

  output logic                         rf_we_o,
  output rf_addr_t                     rf_waddr_o,
  output rf_data_t                     rf_wdata_o
);

  localparam int unsigned PtrW = idx_width(NUM_AUX);
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  rf_wport_arb_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                wb_stall_q;

  logic                wb_occupy;
  logic [NUM_AUX-1:0]  gnt;
  logic [PtrW-1:0]     gnt_idx;
  logic                xfer;
  logic                any_valid;
  logic                blocked;

  cv32e40s_rr_pick #(
    .N    (NUM_AUX),
    .PtrW (PtrW)
  ) u_rr_pick (
    .req_i     (aux_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // A WB write to x0 is discarded, so it leaves the port to the auxiliary writers.
  assign wb_occupy   = wb_we_i && (wb_waddr_i != '0);
  assign aux_ready_o = (!rst && !wb_occupy) ? gnt : '0;
  assign xfer        = |(aux_valid_i & aux_ready_o);
  assign any_valid   = |aux_valid_i;
  assign blocked     = any_valid && !xfer;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = wb_waddr_i;
    rf_wdata_o = wb_wdata_i;
    if (wb_occupy) begin
      rf_we_o = 1'b1;
    end else if (xfer) begin
      rf_waddr_o = aux_waddr_i[gnt_idx];
      rf_wdata_o = aux_wdata_i[gnt_idx];
      rf_we_o    = (aux_waddr_i[gnt_idx] != '0);
    end
    if (rst) begin
      rf_we_o = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == PtrW'(NUM_AUX - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ArbIdle: begin
        cnt_d = '0;
        if (blocked) begin
          cnt_d   = CntW'(1);
          state_d = (STARVE_LIMIT == 1) ? ArbStall : ArbWait;
        end
      end
      ArbWait: begin
        if (!blocked) begin
          state_d = ArbIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 >= CntW'(STARVE_LIMIT)) begin
            state_d = ArbStall;
          end
        end
      end
      ArbStall: begin
        // Returns to idle even if WB ignored the stall and kept the port.
        state_d = ArbIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = ArbIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ArbIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_stall_q <= (state_d == ArbStall);
    end
  end

  assign wb_stall_o = wb_stall_q;

  // Auxiliary writers must hold their request stable until it is accepted.
  for (genvar i = 0; i < int'(NUM_AUX); i++) begin : g_hold_chk
    a_aux_hold : assert property (
      @(posedge clk) disable iff (rst)
      (aux_valid_i[i] && !aux_ready_o[i]) |=>
        (aux_valid_i[i] && $stable(aux_waddr_i[i]) && $stable(aux_wdata_i[i]))
    ) else $error("aux writer %0d dropped or changed a pending request", i);
  end

endmodule

// File: tb/tb_cv32e40s_rf_wport_arbiter.sv
module tb_cv32e40s_rf_wport_arbiter;
  import cv32e40s_pkg::*;

  logic               clk;
  logic               rst;
  logic               wb_we_i;
  rf_addr_t           wb_waddr_i;
  rf_data_t           wb_wdata_i;
  logic               wb_stall_o;
  logic     [1:0]     aux_valid_i;
  rf_addr_t [1:0]     aux_waddr_i;
  rf_data_t [1:0]     aux_wdata_i;
  logic     [1:0]     aux_ready_o;
  logic               rf_we_o;
  rf_addr_t           rf_waddr_o;
  rf_data_t           rf_wdata_o;

  int unsigned n_tests;
  int unsigned n_fail;

  cv32e40s_rf_wport_arbiter #(
    .NUM_AUX      (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_we_i     (wb_we_i),
    .wb_waddr_i  (wb_waddr_i),
    .wb_wdata_i  (wb_wdata_i),
    .wb_stall_o  (wb_stall_o),
    .aux_valid_i (aux_valid_i),
    .aux_waddr_i (aux_waddr_i),
    .aux_wdata_i (aux_wdata_i),
    .aux_ready_o (aux_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    wb_we_i     = 1'b0;
    wb_waddr_i  = '0;
    wb_wdata_i  = '0;
    aux_valid_i = 2'b01;
    aux_waddr_i = '0;
    aux_wdata_i = '0;
    aux_waddr_i[0] = 5'd5;
    aux_wdata_i[0] = 32'hDEADBEEF;

    // Reset: outputs forced low regardless of a pending request.
    #12;
    check("rst_ready", 32'(aux_ready_o), 32'h0);
    check("rst_we", 32'(rf_we_o), 32'h0);
    check("rst_stall", 32'(wb_stall_o), 32'h0);
    check("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
    check("rst_cnt", 32'(dut.cnt_q), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Single aux0 write to x5.
    check("t1_ready", 32'(aux_ready_o), 32'h1);
    check("t1_we", 32'(rf_we_o), 32'h1);
    check("t1_waddr", 32'(rf_waddr_o), 32'd5);
    check("t1_wdata", rf_wdata_o, 32'hDEADBEEF);
    cyc();
    check("t1_ptr", 32'(dut.rr_ptr_q), 32'h1);

    // Both aux valid: ptr=1 so grants go aux1, aux0, aux1, then aux0 alone.
    aux_valid_i    = 2'b11;
    aux_waddr_i[0] = 5'd1;
    aux_wdata_i[0] = 32'h11;
    aux_waddr_i[1] = 5'd2;
    aux_wdata_i[1] = 32'h22;
    #1;
    check("t2_g0", 32'(aux_ready_o), 32'h2);
    check("t2_a0", 32'(rf_waddr_o), 32'd2);
    cyc();
    check("t2_g1", 32'(aux_ready_o), 32'h1);
    check("t2_a1", 32'(rf_waddr_o), 32'd1);
    check("t2_d1", rf_wdata_o, 32'h11);
    cyc();
    check("t2_g2", 32'(aux_ready_o), 32'h2);
    cyc();
    aux_valid_i = 2'b01;
    #1;
    check("t2_g3", 32'(aux_ready_o), 32'h1);
    cyc();
    aux_valid_i = 2'b00;
    check("t2_ptr", 32'(dut.rr_ptr_q), 32'h1);

    // Starvation: WB writes x3 every cycle while aux1 waits.
    wb_we_i        = 1'b1;
    wb_waddr_i     = 5'd3;
    wb_wdata_i     = 32'h33;
    aux_valid_i    = 2'b10;
    aux_waddr_i[1] = 5'd9;
    aux_wdata_i[1] = 32'h99;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("t3_ready_c%0d", c + 1), 32'(aux_ready_o), 32'h0);
      check($sformatf("t3_stall_c%0d", c + 1), 32'(wb_stall_o), 32'h0);
      check($sformatf("t3_waddr_c%0d", c + 1), 32'(rf_waddr_o), 32'd3);
      cyc();
    end
    wb_we_i = 1'b0;
    #1;
    check("t3_stall_c5", 32'(wb_stall_o), 32'h1);
    check("t3_ready_c5", 32'(aux_ready_o), 32'h2);
    check("t3_waddr_c5", 32'(rf_waddr_o), 32'd9);
    check("t3_wdata_c5", rf_wdata_o, 32'h99);
    cyc();
    aux_valid_i = 2'b00;
    check("t3_stall_c6", 32'(wb_stall_o), 32'h0);
    check("t3_state_c6", 32'(dut.state_q), 32'(ArbIdle));
    check("t3_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // WB write to x0 yields the port to aux0.
    wb_we_i        = 1'b1;
    wb_waddr_i     = 5'd0;
    wb_wdata_i     = 32'h55;
    aux_valid_i    = 2'b01;
    aux_waddr_i[0] = 5'd7;
    aux_wdata_i[0] = 32'h77;
    #1;
    check("t4_ready", 32'(aux_ready_o), 32'h1);
    check("t4_we", 32'(rf_we_o), 32'h1);
    check("t4_waddr", 32'(rf_waddr_o), 32'd7);
    cyc();
    wb_we_i     = 1'b0;
    aux_valid_i = 2'b00;
    check("t4_cnt", 32'(dut.cnt_q), 32'h0);
    check("t4_ptr", 32'(dut.rr_ptr_q), 32'h1);

    // aux1 write to x0: handshake completes, no register write.
    aux_valid_i    = 2'b10;
    aux_waddr_i[1] = 5'd0;
    aux_wdata_i[1] = 32'hAA;
    #1;
    check("t5_ready", 32'(aux_ready_o), 32'h2);
    check("t5_we", 32'(rf_we_o), 32'h0);
    cyc();
    aux_valid_i = 2'b00;
    check("t5_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // Reset while waiting with cnt=2; the held request survives reset.
    wb_we_i        = 1'b1;
    wb_waddr_i     = 5'd3;
    aux_valid_i    = 2'b01;
    aux_waddr_i[0] = 5'd4;
    aux_wdata_i[0] = 32'h44;
    #1;
    check("t6_ready_blk", 32'(aux_ready_o), 32'h0);
    cyc();
    cyc();
    check("t6_cnt_pre", 32'(dut.cnt_q), 32'h2);
    check("t6_state_pre", 32'(dut.state_q), 32'(ArbWait));
    rst = 1'b1;
    #1;
    check("t6_cnt_rst", 32'(dut.cnt_q), 32'h0);
    check("t6_state_rst", 32'(dut.state_q), 32'(ArbIdle));
    check("t6_ptr_rst", 32'(dut.rr_ptr_q), 32'h0);
    check("t6_ready_rst", 32'(aux_ready_o), 32'h0);
    check("t6_we_rst", 32'(rf_we_o), 32'h0);
    check("t6_stall_rst", 32'(wb_stall_o), 32'h0);
    wb_we_i = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_ready_post", 32'(aux_ready_o), 32'h1);
    check("t6_waddr_post", 32'(rf_waddr_o), 32'd4);
    check("t6_we_post", 32'(rf_we_o), 32'h1);
    cyc();
    aux_valid_i = 2'b00;
    check("t6_ptr_post", 32'(dut.rr_ptr_q), 32'h1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
